// File: rtl/pcs_rx_sync_16bit.sv
// 8b10b word-sync acquisition/monitor on K28.5 commas for a 16-bit PHY RX path.
// Optional running-disparity tracker built when PCS_RX_DISPARITY_EN is defined.
module pcs_rx_sync_16bit #(
  parameter int g_err_cnt_width  = 16,
  parameter int g_commas_to_sync = 3,
  parameter int g_bad_to_loss    = 4
) (
  input  logic                       clk_rx_i,
  input  logic                       rst_i,
  input  logic [15:0]                rx_data_i,
  input  logic [1:0]                 rx_k_i,
  input  logic                       rx_enc_err_i,
  output logic                       synced_o,
  output logic [15:0]                rx_data_o,
  output logic [1:0]                 rx_k_o,
  output logic                       rx_valid_o,
  output logic                       rx_disparity_o,
  output logic [g_err_cnt_width-1:0] err_cnt_o,
  output logic                       los_event_o
);

  localparam int BW = (g_bad_to_loss > 1) ? $clog2(g_bad_to_loss) : 1;
  localparam logic [2:0]    C_LAST   = 3'(g_commas_to_sync - 1);
  localparam logic [BW-1:0] BAD_LAST = BW'(g_bad_to_loss - 1);

  typedef enum logic [1:0] {LOS, ACQ, SYNC} state_t;

  state_t                      r_state;
  logic [2:0]                  r_comma_cnt;
  logic [BW-1:0]               r_bad_cnt;
  logic [1:0]                  r_good_cnt;
  logic [g_err_cnt_width-1:0]  r_err_cnt;
  logic                        r_synced, r_valid, r_los;
  logic [15:0]                 r_data;
  logic [1:0]                  r_k;

  logic w_comma, w_misal, w_invalid, w_acq_done, w_loss, w_ns_sync;

  assign w_comma    = rx_k_i[1] && (rx_data_i[15:8] == 8'hBC) && !rx_enc_err_i;
  assign w_misal    = rx_k_i[0] && (rx_data_i[7:0] == 8'hBC);
  assign w_invalid  = rx_enc_err_i || w_misal;
  assign w_acq_done = (r_state == ACQ) && w_comma && !w_invalid && (r_comma_cnt == C_LAST);
  assign w_loss     = (r_state == SYNC) && w_invalid && (r_bad_cnt == BAD_LAST);
  assign w_ns_sync  = w_acq_done || ((r_state == SYNC) && !w_loss);

  always_ff @(posedge clk_rx_i) begin
    if (rst_i) begin
      r_state     <= LOS;
      r_comma_cnt <= '0;
      r_bad_cnt   <= '0;
      r_good_cnt  <= '0;
      r_err_cnt   <= '0;
      r_synced    <= 1'b0;
      r_valid     <= 1'b0;
      r_los       <= 1'b0;
      r_data      <= '0;
      r_k         <= '0;
    end else begin
      r_data   <= rx_data_i;
      r_k      <= rx_k_i;
      r_synced <= w_ns_sync;
      r_valid  <= w_ns_sync && !w_invalid;
      r_los    <= w_loss;
      if (w_invalid && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      case (r_state)
        LOS: if (w_comma && !w_invalid) begin
          r_state     <= ACQ;
          r_comma_cnt <= 3'd1;
        end
        ACQ: begin
          if (w_invalid) begin
            r_state     <= LOS;
            r_comma_cnt <= '0;
          end else if (w_comma) begin
            if (w_acq_done) begin
              r_state     <= SYNC;
              r_comma_cnt <= '0;
              r_bad_cnt   <= '0;
              r_good_cnt  <= '0;
            end else begin
              r_comma_cnt <= r_comma_cnt + 3'd1;
            end
          end
        end
        SYNC: begin
          if (w_invalid) begin
            r_good_cnt <= '0;
            if (w_loss) begin
              r_state   <= LOS;
              r_bad_cnt <= '0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end else if (r_bad_cnt != '0) begin
            // four good words in a row earn back one bad credit
            if (r_good_cnt == 2'd3) begin
              r_bad_cnt  <= r_bad_cnt - 1'b1;
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + 2'd1;
            end
          end
        end
        default: r_state <= LOS;
      endcase
    end
  end

`ifdef PCS_RX_DISPARITY_EN
  localparam logic [31:0] C_DP6 = 32'b11101000100000011000000110010111;
  localparam logic [7:0]  C_DP4 = 8'b10001001;

  function automatic logic rd_byte(input logic rd, input logic [7:0] d, input logic k);
    logic dp6, dp4;
    dp6 = C_DP6[5'd31 - d[4:0]];
    dp4 = C_DP4[3'd7 - d[7:5]];
    if (k && (d[1:0] != 2'b00)) return rd;
    return rd ^ (k ^ dp6 ^ dp4);
  endfunction

  logic r_rd;
  always_ff @(posedge clk_rx_i) begin
    if (rst_i) r_rd <= 1'b0;
    else       r_rd <= rd_byte(rd_byte(r_rd, rx_data_i[15:8], rx_k_i[1]), rx_data_i[7:0], rx_k_i[0]);
  end
  assign rx_disparity_o = r_rd;
`else
  assign rx_disparity_o = 1'b0;
`endif

  assign synced_o    = r_synced;
  assign rx_data_o   = r_data;
  assign rx_k_o      = r_k;
  assign rx_valid_o  = r_valid;
  assign err_cnt_o   = r_err_cnt;
  assign los_event_o = r_los;

endmodule

// File: tb/tb_pcs_rx_sync_16bit.sv
// Directed table-driven bench for pcs_rx_sync_16bit (default parameters).
module tb_pcs_rx_sync_16bit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic        rx_err;
  logic        synced, valid, disp, los;
  logic [15:0] data_o, err_cnt;
  logic [1:0]  k_o;

  int n_chk = 0;
  int n_fail = 0;

  pcs_rx_sync_16bit dut (
    .clk_rx_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_k_i(rx_k),
    .rx_enc_err_i(rx_err), .synced_o(synced), .rx_data_o(data_o), .rx_k_o(k_o),
    .rx_valid_o(valid), .rx_disparity_o(disp), .err_cnt_o(err_cnt), .los_event_o(los)
  );

  always #5 clk = ~clk;

  // word kinds: C comma, D data, E encode error, M misaligned comma, X comma+misaligned
  typedef enum int {C, D, E, M, X} kind_t;

  typedef struct {
    logic        rst;
    logic [15:0] data;
    logic [1:0]  k;
    logic        err;
    logic        e_sync;
    logic        e_valid;
    logic [15:0] e_cnt;
    logic        e_los;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input kind_t kd, input logic s,
                              input logic v, input int e, input logic l);
    vec_t t;
    t.rst = r; t.err = 1'b0;
    case (kd)
      C: begin t.data = 16'hBC50; t.k = 2'b10; end
      D: begin t.data = 16'h1234; t.k = 2'b00; end
      E: begin t.data = 16'h5A5A; t.k = 2'b00; t.err = 1'b1; end
      M: begin t.data = 16'h00BC; t.k = 2'b01; end
      default: begin t.data = 16'hBCBC; t.k = 2'b11; end
    endcase
    t.e_sync = s; t.e_valid = v; t.e_cnt = 16'(e); t.e_los = l;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [15:0] d, input logic [1:0] k, input logic e);
    rst = r; rx_data = d; rx_k = k; rx_err = e;
    @(posedge clk);
    #1;
  endtask

  logic exp_rd;

  initial begin
    rst = 1'b1; rx_data = '0; rx_k = '0; rx_err = 1'b0;

    // reset
    tbl.push_back(mk(1, C, 0, 0, 0, 0));
    // acquisition
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 1, 1, 0, 0));
    tbl.push_back(mk(0, D, 1, 1, 0, 0));
    // interrupted acquisition (error at comma_cnt = N-1)
    tbl.push_back(mk(1, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, E, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 1, 1, 1, 0));
    // loss of sync, one bad word being a misaligned comma
    tbl.push_back(mk(1, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 1, 1, 0, 0));
    tbl.push_back(mk(0, E, 1, 0, 1, 0));
    tbl.push_back(mk(0, E, 1, 0, 2, 0));
    tbl.push_back(mk(0, M, 1, 0, 3, 0));
    tbl.push_back(mk(0, E, 0, 0, 4, 1));
    tbl.push_back(mk(0, D, 0, 0, 4, 0));
    // recovery: 3 bad, 12 good, 3 bad stays in SYNC
    tbl.push_back(mk(1, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, C, 1, 1, 0, 0));
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(0, E, 1, 0, i, 0));
    for (int i = 0; i < 12; i++) tbl.push_back(mk(0, D, 1, 1, 3, 0));
    for (int i = 4; i <= 6; i++) tbl.push_back(mk(0, E, 1, 0, i, 0));
    tbl.push_back(mk(0, D, 1, 1, 6, 0));
    // reset mid-SYNC with an invalid word present: no pulse, no count
    tbl.push_back(mk(1, E, 0, 0, 0, 0));
    tbl.push_back(mk(0, D, 0, 0, 0, 0));
    // comma word that also carries a misaligned comma is invalid
    tbl.push_back(mk(0, C, 0, 0, 0, 0));
    tbl.push_back(mk(0, X, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 0, 0, 1, 0));
    tbl.push_back(mk(0, C, 1, 1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].data, tbl[i].k, tbl[i].err);
      chk($sformatf("synced[%0d]", i), {15'd0, synced}, {15'd0, tbl[i].e_sync});
      chk($sformatf("valid[%0d]", i),  {15'd0, valid},  {15'd0, tbl[i].e_valid});
      chk($sformatf("errcnt[%0d]", i), err_cnt,         tbl[i].e_cnt);
      chk($sformatf("los[%0d]", i),    {15'd0, los},    {15'd0, tbl[i].e_los});
      chk($sformatf("data[%0d]", i),   data_o,          tbl[i].rst ? 16'h0 : tbl[i].data);
      chk($sformatf("k[%0d]", i),      {14'd0, k_o},    {14'd0, (tbl[i].rst ? 2'b00 : tbl[i].k)});
    end

    // disparity sequence from reset: BC00/K -> 1, 0000 -> hold, BC00/K -> 0, 0000 -> hold
    apply(1'b1, 16'hBC00, 2'b10, 1'b0);
    chk("disp_rst", {15'd0, disp}, 16'd0);
    exp_rd = 1'b0;
`ifdef PCS_RX_DISPARITY_EN
    exp_rd = 1'b1;
`endif
    apply(1'b0, 16'hBC00, 2'b10, 1'b0);
    chk("disp_k1", {15'd0, disp}, {15'd0, exp_rd});
    apply(1'b0, 16'h0000, 2'b00, 1'b0);
    chk("disp_d1", {15'd0, disp}, {15'd0, exp_rd});
    apply(1'b0, 16'hBC00, 2'b10, 1'b0);
    chk("disp_k2", {15'd0, disp}, 16'd0);
    apply(1'b0, 16'h0000, 2'b00, 1'b0);
    chk("disp_d2", {15'd0, disp}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pcs_rx_sync_16bit.md
# pcs_rx_sync_16bit

Receive-side companion to the 16-bit PHY transmit path in the endpoint simulation environment. It sits between the PHY receive interface (`rx_data`, `rx_k`, `rx_enc_err`) and the endpoint RX PCS. It acquires and monitors 8b10b word synchronisation on K28.5 commas, and forwards aligned words only while synchronised. It also tracks the predicted running disparity with the same per-byte rule the TX model uses, and counts code errors.

## Interface
- `g_err_cnt_width`, default 16: width of the saturating error counter.
- `g_commas_to_sync`, default 3: consecutive comma words needed to reach SYNC (range 2..7).
- `g_bad_to_loss`, default 4: net bad words in SYNC that force loss of sync.
- `clk_rx_i`, in, 1: receive word clock (one 16-bit word per cycle).
- `rst_i`, in, 1: synchronous, active-high reset.
- `rx_data_i`, in, 16: decoded word; [15:8] is the first byte on the wire.
- `rx_k_i`, in, 2: control flags; [1] qualifies [15:8], [0] qualifies [7:0].
- `rx_enc_err_i`, in, 1: decoder code/disparity error for this word.
- `synced_o`, out, 1: high while in SYNC.
- `rx_data_o`, out, 16: registered copy of `rx_data_i`.
- `rx_k_o`, out, 2: registered copy of `rx_k_i`.
- `rx_valid_o`, out, 1: word on `rx_data_o`/`rx_k_o` is valid and aligned.
- `rx_disparity_o`, out, 1: running disparity after the current word (0 = RD−).
- `err_cnt_o`, out, `g_err_cnt_width`: count of invalid words; saturates at all-ones.
- `los_event_o`, out, 1: one-cycle pulse on each SYNC→LOS transition.

## Operation
- **Comma word:** `rx_k_i[1]`=1, `rx_data_i[15:8]`=0xBC, `rx_enc_err_i`=0.
- **Invalid word:** `rx_enc_err_i`=1, or a misaligned comma (`rx_k_i[0]`=1 and `rx_data_i[7:0]`=0xBC).
- **Valid word:** any word that is not invalid.
- FSM states: LOS, ACQ, SYNC. Internal counters: `comma_cnt` 0..7, `bad_cnt` 0..g_bad_to_loss−1, `good_cnt` 0..3.
- **LOS:**
  - A comma word moves the FSM to ACQ with `comma_cnt`=1.
  - Any other word keeps it in LOS.
- **ACQ:**
  - An invalid word moves the FSM to LOS.
  - A comma word increments `comma_cnt`. When the count reaches `g_commas_to_sync`, the FSM moves to SYNC with `bad_cnt`=`good_cnt`=0.
  - A valid non-comma word holds the FSM and the count.
- **SYNC:**
  - An invalid word increments `bad_cnt` and clears `good_cnt`. If `bad_cnt` was already g_bad_to_loss−1, the FSM moves to LOS and pulses `los_event_o`.
  - A valid word with `bad_cnt`>0 increments `good_cnt`. When `good_cnt` reaches 4, `bad_cnt` decrements and `good_cnt` clears.
  - A valid word with `bad_cnt`=0 holds both counters at 0.
- `err_cnt_o` increments on every invalid word in any state except during reset. It holds at all-ones once saturated.
- `rx_valid_o` = registered (next state == SYNC and current word valid). The word that completes acquisition is therefore marked valid.
- **Disparity rule per byte** (upper byte first, then lower byte using the result of the upper):
  - `dp6` = bit `data[4:0]` of 32'b11101000100000011000000110010111, MSB-first index 0..31.
  - `dp4` = bit `data[7:5]` of 8'b10001001, MSB-first.
  - The disparity flips when `k^dp6^dp4`=1.
  - Exception: when k=1 and `data[1:0]`≠0, the disparity holds.
- Disparity updates on every word regardless of FSM state.

## Timing
- All outputs are registered. Latency from input word to `rx_*_o`, `synced_o` and `rx_disparity_o` is 1 cycle.
- `synced_o` rises 1 cycle after the clock edge that samples the g_commas_to_sync-th comma word.
- Values while `rst_i` is high, and on the first edge after it deasserts:
  - FSM = LOS, all counters 0.
  - `synced_o`=0, `rx_valid_o`=0, `rx_data_o`=0, `rx_k_o`=0, `rx_disparity_o`=0, `err_cnt_o`=0, `los_event_o`=0.
- Reset asserted mid-SYNC takes effect at the next edge: no `los_event_o` pulse and no error count for that cycle.
- Boundary cases:
  - An invalid word arriving in ACQ while `comma_cnt`=g_commas_to_sync−1 goes to LOS, not SYNC.
  - A misaligned comma in SYNC counts as bad even when `rx_enc_err_i`=0.
  - A word that is both a comma word and carries a misaligned comma in [7:0] is invalid.

## Configuration
- `PCS_RX_DISPARITY_EN` defined: disparity tracker is built and `rx_disparity_o` follows the rule in Operation.
- `PCS_RX_DISPARITY_EN` undefined: no tracker logic; `rx_disparity_o` is tied to 0. All other behaviour is unchanged.

## Test plan
- **Acquisition:** after reset, send 0xBC50/k=10 three times, then 0x1234/k=00 → `synced_o`=1 one cycle after the third comma; `rx_valid_o`=1 from that word onward; `err_cnt_o`=0.
- **Interrupted acquisition:** two commas, then `rx_enc_err_i`=1, then three commas → no SYNC until the fifth comma; `err_cnt_o`=1.
- **Loss of sync:** in SYNC, send four invalid words with no valid word between them → `los_event_o` pulses once; `synced_o`=0; `err_cnt_o`=4.
- **Recovery:** in SYNC, send 3 invalid words, 12 valid, then 3 invalid → remains in SYNC (`bad_cnt` back to 0 before the second burst); `err_cnt_o`=6.
- **Disparity:** from reset (RD 0), 0xBC00/k=10 → `rx_disparity_o`=1; a second 0xBC00/k=10 → 0; 0x0000/k=00 → unchanged. With the macro undefined → always 0.
- **Reset mid-SYNC:** assert `rst_i` for one cycle in SYNC → all outputs at reset values next cycle; `los_event_o` stays 0.
